// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port master: merges ALU results and load returns into one
// registered write per cycle, buffers colliding loads in order, tracks load-pending registers.
module rf_writeback_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [ADDR_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_WIDTH-1:0]    ld_rd,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     iss_valid,
  input  logic [ADDR_WIDTH-1:0]    iss_rd,
  input  logic [ADDR_WIDTH-1:0]    q_rs1,
  input  logic [ADDR_WIDTH-1:0]    q_rs2,
  input  logic [ADDR_WIDTH-1:0]    q_rd,
  output logic                     hazard,
  output logic [ADDR_WIDTH-1:0]    A3,
  output logic                     WE3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic [2**ADDR_WIDTH-1:0] pending
);

  localparam int NREG  = 2 ** ADDR_WIDTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_FIFO = 2'd2;
  localparam logic [1:0] SRC_BYP  = 2'd3;

  // Load handshake: a load transfers on any cycle where ld_valid && ld_ready.
  // ld_ready depends on stored occupancy only, never on this cycle's pop.
  logic [ADDR_WIDTH-1:0] fifo_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  ld_acc;
  logic [1:0]            src_sel;
  logic                  push;
  logic                  pop;
  logic                  wr_any;
  logic [ADDR_WIDTH-1:0] wr_rd;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_from_ld;
  logic [NREG-1:0]       set_mask;
  logic [NREG-1:0]       clr_mask;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign ld_ready   = !fifo_full;
  assign ld_acc     = ld_valid && ld_ready;

  always_comb begin
    src_sel = SRC_NONE;
    if (alu_valid)        src_sel = SRC_ALU;
    else if (!fifo_empty) src_sel = SRC_FIFO;
    else if (ld_acc)      src_sel = SRC_BYP;
  end

  assign pop  = (src_sel == SRC_FIFO);
  assign push = ld_acc && (src_sel != SRC_BYP);

  always_comb begin
    wr_any     = 1'b0;
    wr_rd      = '0;
    wr_data    = '0;
    wr_from_ld = 1'b0;
    case (src_sel)
      SRC_ALU: begin
        wr_any  = 1'b1;
        wr_rd   = alu_rd;
        wr_data = alu_data;
      end
      SRC_FIFO: begin
        wr_any     = 1'b1;
        wr_rd      = fifo_rd[rd_ptr];
        wr_data    = fifo_data[rd_ptr];
        wr_from_ld = 1'b1;
      end
      SRC_BYP: begin
        wr_any     = 1'b1;
        wr_rd      = ld_rd;
        wr_data    = ld_data;
        wr_from_ld = 1'b1;
      end
      default: begin
        wr_any = 1'b0;
      end
    endcase
  end

  // Writes to r0 consume the slot but never enable the port or touch the scoreboard.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && (iss_rd != '0))
      set_mask = NREG'(1) << iss_rd;
    if (wr_any && wr_from_ld && (wr_rd != '0))
      clr_mask = NREG'(1) << wr_rd;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A3  <= '0;
      WD3 <= '0;
      WE3 <= 1'b0;
    end else begin
      WE3 <= wr_any && (wr_rd != '0);
      if (wr_any) begin
        A3  <= wr_rd;
        WD3 <= wr_data;
      end
    end
  end

  // Set wins over a same-edge clear of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

  assign hazard = pending[q_rs1] | pending[q_rs2] | pending[q_rd];

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomized and directed bench for rf_writeback_arbiter against a queue-based reference model.
module tb_rf_writeback_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NREG  = 2 ** AW;

  logic            clk;
  logic            rst_n;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [DW-1:0]   alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [DW-1:0]   ld_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   q_rs1;
  logic [AW-1:0]   q_rs2;
  logic [AW-1:0]   q_rd;
  logic            hazard;
  logic [AW-1:0]   A3;
  logic            WE3;
  logic [DW-1:0]   WD3;
  logic [NREG-1:0] pending;

  rf_writeback_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .hazard(hazard),
    .A3(A3), .WE3(WE3), .WD3(WD3), .pending(pending)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: buffered loads in acceptance order, expected port state, pending set.
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    m_a3;
  logic [DW-1:0]    m_wd;
  logic             m_we;
  logic [NREG-1:0]  m_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0;  ld_rd = '0;  ld_data = '0;
    iss_valid = 0; iss_rd = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_a3 = '0; m_wd = '0; m_we = 1'b0; m_pend = '0;
  endtask

  // Called at a negedge with inputs already set; checks comb outputs, advances one edge, checks registers.
  task automatic step();
    logic          acc;
    logic          wrote;
    logic          from_ld;
    logic [AW-1:0] w_rd;
    logic [DW-1:0] w_data;
    logic [AW+DW-1:0] e;
    #1;
    assert (!(iss_valid && iss_rd != 0 && m_pend[iss_rd]))
      else $error("driver issued a load to an already pending register");
    check("ld_ready", ld_ready, exp_q.size() < DEPTH);
    check("hazard", hazard, m_pend[q_rs1] | m_pend[q_rs2] | m_pend[q_rd]);
    acc = ld_valid && (exp_q.size() < DEPTH);
    wrote = 1'b1; from_ld = 1'b0; w_rd = '0; w_data = '0;
    if (alu_valid) begin
      w_rd = alu_rd; w_data = alu_data;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {w_rd, w_data} = e;
      from_ld = 1'b1;
    end else if (acc) begin
      w_rd = ld_rd; w_data = ld_data;
      from_ld = 1'b1;
      acc = 1'b0;
    end else begin
      wrote = 1'b0;
    end
    if (acc) exp_q.push_back({ld_rd, ld_data});
    m_we = wrote && (w_rd != 0);
    if (wrote) begin
      m_a3 = w_rd; m_wd = w_data;
    end
    if (wrote && from_ld && w_rd != 0) m_pend[w_rd] = 1'b0;
    if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    @(negedge clk);
    check("WE3", WE3, m_we);
    check("A3", A3, m_a3);
    check("WD3", WD3, m_wd);
    check("pending", pending, m_pend);
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_WE3", WE3, 0);
    check("rst_A3", A3, 0);
    check("rst_WD3", WD3, 0);
    check("rst_pending", pending, 0);
    check("rst_ld_ready", ld_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU only
    set_idle();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    check("alu_A3", A3, 5);
    check("alu_WD3", WD3, 32'hDEADBEEF);
    check("alu_WE3", WE3, 1);
    set_idle();
    step();
    check("alu_WE3_one_cycle", WE3, 0);
    check("alu_A3_hold", A3, 5);

    // Collision: ALU wins, load follows next cycle
    set_idle();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    ld_valid = 1;  ld_rd = 7;  ld_data = 32'h22;
    step();
    check("col_first_A3", A3, 3);
    set_idle();
    step();
    check("col_second_A3", A3, 7);
    check("col_second_WD3", WD3, 32'h22);
    check("col_second_WE3", WE3, 1);

    // Backpressure: ALU holds the port while four loads fill the FIFO
    for (int i = 0; i < 4; i++) begin
      set_idle();
      alu_valid = 1; alu_rd = AW'(i + 1); alu_data = 32'h100 + i;
      ld_valid = 1;  ld_rd = AW'(i + 10); ld_data = 32'h200 + i;
      step();
    end
    check("bp_full", ld_ready, 0);
    for (int i = 0; i < 4; i++) begin
      set_idle();
      step();
      check("bp_order_A3", A3, i + 10);
      check("bp_order_WD3", WD3, 32'h200 + i);
      check("bp_ready_after_pop", ld_ready, 1);
    end

    // Scoreboard set and clear
    set_idle();
    iss_valid = 1; iss_rd = 9;
    step();
    check("sb_pending9", pending[9], 1);
    set_idle();
    q_rs1 = 9;
    ld_valid = 1; ld_rd = 9; ld_data = 32'hCAFE;
    step();
    check("sb_hazard_set", 1'(m_pend[9]), 0);
    check("sb_cleared_with_we", {WE3, pending[9]}, 2'b10);
    set_idle();
    q_rs1 = 9;
    step();

    // x0 writes and issues
    set_idle();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
    iss_valid = 1; iss_rd = 0;
    step();
    check("x0_WE3", WE3, 0);
    check("x0_A3", A3, 0);
    check("x0_pending", pending, 0);

    // Reset mid-stream with three loads buffered
    for (int i = 0; i < 3; i++) begin
      set_idle();
      alu_valid = 1; alu_rd = AW'(20 + i); alu_data = 32'h300 + i;
      ld_valid = 1;  ld_rd = AW'(25 + i);  ld_data = 32'h400 + i;
      iss_valid = 1; iss_rd = AW'(15 + i);
      step();
    end
    set_idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_WE3", WE3, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_ld_ready", ld_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_empty", WE3, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] r;
      set_idle();
      alu_valid = ($urandom_range(0, 99) < 40);
      alu_rd    = AW'($urandom_range(0, NREG - 1));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 99) < 55);
      ld_rd     = AW'($urandom_range(0, NREG - 1));
      ld_data   = $urandom;
      r = AW'($urandom_range(0, NREG - 1));
      if ($urandom_range(0, 3) == 0 && !m_pend[r]) begin
        iss_valid = 1; iss_rd = r;
      end
      q_rs1 = AW'($urandom_range(0, NREG - 1));
      q_rs2 = AW'($urandom_range(0, NREG - 1));
      q_rd  = AW'($urandom_range(0, NREG - 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
